// File: rtl/modulo_transmisor_hamming.sv
// SECDED(8,4) transmitter: encodes a 4-bit word and sends it LSB first, framed by start/stop bits.
// Optional build macro HAMMING_INYECCION_EN XORs the captured `inyectar` mask into the sent word.
module modulo_transmisor_hamming #(
    parameter int unsigned CICLOS_POR_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] datos_in,
    input  logic       valido,
    output logic       listo,
    input  logic [7:0] inyectar,
    output logic       tx,
    output logic [7:0] palabra_cod,
    output logic       ocupado,
    output logic       fin
);

    localparam int unsigned CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_POR_BIT - 1);

    typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_sig;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic [7:0]    cod;
    logic [7:0]    palabra_tx;

    // Hamming positions 1..7 at bit index position-1; bit 7 is even overall parity.
    function automatic logic [7:0] codificar(input logic [3:0] d);
        logic [6:0] c;
        c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        return {^c, c};
    endfunction

    assign cod     = codificar(datos_in);
    assign cnt_sig = cnt + 1'b1;

`ifdef HAMMING_INYECCION_EN
    assign palabra_tx = cod ^ inyectar;
`else
    logic unused_inyectar;
    assign unused_inyectar = ^inyectar;
    assign palabra_tx      = cod;
`endif

    assign listo   = (estado == REPOSO);
    assign ocupado = !listo;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= REPOSO;
            tx          <= 1'b1;
            fin         <= 1'b0;
            palabra_cod <= '0;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
        end else begin
            fin <= 1'b0;
            case (estado)
                REPOSO: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (valido) begin
                        estado      <= INICIO;
                        tx          <= 1'b0;
                        palabra_cod <= cod;
                        sh          <= palabra_tx;
                        idx         <= '0;
                    end
                end
                INICIO: begin
                    if (cnt == CNT_MAX) begin
                        cnt    <= '0;
                        estado <= DATOS;
                        tx     <= sh[0];
                        sh     <= {1'b0, sh[7:1]};
                    end else begin
                        cnt <= cnt_sig;
                    end
                end
                DATOS: begin
                    if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            estado <= PARADA;
                            tx     <= 1'b1;
                            // A one-cycle stop bit is also its own last cycle.
                            fin    <= (CICLOS_POR_BIT == 1);
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= sh[0];
                            sh  <= {1'b0, sh[7:1]};
                        end
                    end else begin
                        cnt <= cnt_sig;
                    end
                end
                PARADA: begin
                    if (cnt == CNT_MAX) begin
                        cnt    <= '0;
                        estado <= REPOSO;
                    end else begin
                        cnt <= cnt_sig;
                        fin <= (cnt_sig == CNT_MAX);
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_transmisor_hamming.sv
// Directed bench for modulo_transmisor_hamming: N=4 frames, mid-frame reset, injection,
// and back-to-back N=1 frames on a second instance.
module tb_modulo_transmisor_hamming;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] datos_in;
    logic       valido;
    logic       listo;
    logic [7:0] inyectar;
    logic       tx;
    logic [7:0] palabra_cod;
    logic       ocupado;
    logic       fin;

    logic [3:0] datos1;
    logic       valido1;
    logic       listo1;
    logic       tx1;
    logic [7:0] palabra_cod1;
    logic       ocupado1;
    logic       fin1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modulo_transmisor_hamming #(.CICLOS_POR_BIT(N)) dut (
        .clk(clk), .rst(rst), .datos_in(datos_in), .valido(valido), .listo(listo),
        .inyectar(inyectar), .tx(tx), .palabra_cod(palabra_cod), .ocupado(ocupado), .fin(fin)
    );

    modulo_transmisor_hamming #(.CICLOS_POR_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .datos_in(datos1), .valido(valido1), .listo(listo1),
        .inyectar(8'h00), .tx(tx1), .palabra_cod(palabra_cod1), .ocupado(ocupado1), .fin(fin1)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic enviar(input logic [3:0] d, input logic [7:0] m,
                          input logic [7:0] cod_exp, input logic [7:0] tx_exp);
        int unsigned espera;
        logic b;
        espera = 0;
        @(negedge clk);
        while (!listo && espera < 100) begin
            @(negedge clk);
            espera++;
        end
        comprobar("listo_antes", {31'b0, listo}, 32'd1);
        datos_in = d;
        inyectar = m;
        valido   = 1'b1;
        @(posedge clk);
        #1;
        valido   = 1'b0;
        datos_in = ~d;
        inyectar = ~m;
        comprobar("palabra_cod", {24'b0, palabra_cod}, {24'b0, cod_exp});
        for (int i = 0; i < 10 * N; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i < N)          b = 1'b0;
            else if (i < 9 * N) b = tx_exp[(i - N) / N];
            else                b = 1'b1;
            comprobar("tx", {31'b0, tx}, {31'b0, b});
            comprobar("fin", {31'b0, fin}, (i == 10 * N - 1) ? 32'd1 : 32'd0);
            comprobar("ocupado", {31'b0, ocupado}, 32'd1);
        end
        @(posedge clk);
        #1;
        comprobar("listo_fin", {31'b0, listo}, 32'd1);
        comprobar("fin_off", {31'b0, fin}, 32'd0);
        comprobar("palabra_hold", {24'b0, palabra_cod}, {24'b0, cod_exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] tabla_cod [3];
        logic [3:0] tabla_dat [3];
        logic       fin_visto;
        logic       b;
        int         f, pos;

        tabla_cod = '{8'h55, 8'h87, 8'hFF};
        tabla_dat = '{4'b1011, 4'b0001, 4'hF};

        rst = 1'b1; valido = 1'b0; datos_in = '0; inyectar = '0;
        valido1 = 1'b0; datos1 = '0;
        repeat (2) @(posedge clk);
        #1;
        comprobar("rst_tx", {31'b0, tx}, 32'd1);
        comprobar("rst_listo", {31'b0, listo}, 32'd1);
        comprobar("rst_ocupado", {31'b0, ocupado}, 32'd0);
        comprobar("rst_fin", {31'b0, fin}, 32'd0);
        comprobar("rst_palabra", {24'b0, palabra_cod}, 32'h00);
        rst = 1'b0;

        enviar(4'b1011, 8'h00, 8'h55, 8'h55);
        enviar(4'b0001, 8'h00, 8'h87, 8'h87);
        enviar(4'hF,    8'h00, 8'hFF, 8'hFF);
        enviar(4'h0,    8'h00, 8'h00, 8'h00);
`ifdef HAMMING_INYECCION_EN
        enviar(4'b1011, 8'h04, 8'h55, 8'h51);
        enviar(4'b1011, 8'h06, 8'h55, 8'h53);
`else
        enviar(4'b1011, 8'h04, 8'h55, 8'h55);
        enviar(4'b1011, 8'h06, 8'h55, 8'h55);
`endif

        // Reset in the middle of data bit 3 (frame cycles 16..19 after the transfer edge).
        @(negedge clk);
        datos_in = 4'b1011;
        valido   = 1'b1;
        @(posedge clk);
        #1;
        valido = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        comprobar("tx_bit3", {31'b0, tx}, 32'd0);
        comprobar("ocupado_bit3", {31'b0, ocupado}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        comprobar("rstm_tx", {31'b0, tx}, 32'd1);
        comprobar("rstm_listo", {31'b0, listo}, 32'd1);
        comprobar("rstm_ocupado", {31'b0, ocupado}, 32'd0);
        comprobar("rstm_palabra", {24'b0, palabra_cod}, 32'h00);
        comprobar("rstm_fin", {31'b0, fin}, 32'd0);
        fin_visto = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (fin || !tx) fin_visto = 1'b1;
        end
        comprobar("sin_frame_tras_rst", {31'b0, fin_visto}, 32'd0);
        enviar(4'b0001, 8'h00, 8'h87, 8'h87);

        // N=1 instance, valido held high: frames every 11 cycles, data changed mid-frame.
        @(negedge clk);
        datos1  = tabla_dat[0];
        valido1 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            f   = i / 11;
            pos = i % 11;
            if (pos == 0)
                comprobar("palabra_cod1", {24'b0, palabra_cod1}, {24'b0, tabla_cod[f]});
            if (pos == 0)      b = 1'b0;
            else if (pos <= 8) b = tabla_cod[f][pos - 1];
            else               b = 1'b1;
            comprobar("tx1", {31'b0, tx1}, {31'b0, b});
            comprobar("fin1", {31'b0, fin1}, (pos == 9) ? 32'd1 : 32'd0);
            comprobar("listo1", {31'b0, listo1}, (pos == 10) ? 32'd1 : 32'd0);
            if (pos == 4) datos1 = 4'b0110;
            if (pos == 10) begin
                if (f < 2) datos1 = tabla_dat[f + 1];
                else       valido1 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        comprobar("listo1_final", {31'b0, listo1}, 32'd1);
        comprobar("tx1_final", {31'b0, tx1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modulo_transmisor_hamming.md
# modulo_transmisor_hamming

Transmit-side counterpart of the SECDED(8,4) receive path: accepts a 4-bit word over a valid/ready handshake, encodes it into an 8-bit extended Hamming codeword and shifts it out on a single serial line as a framed, bit-timed stream. It sits between the data switches and the receive board's `palabra_rx` path. It also exposes the clean codeword for LED display. Build-time error injection exercises the receiver's single-error-correct and double-error-detect logic.

## Interface
- `CICLOS_POR_BIT`, default 4: clock cycles per serial bit. Legal range ≥ 1. Counter width is `$clog2(CICLOS_POR_BIT)`, minimum 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `datos_in` input 4: data word. d1 = `datos_in[0]`, d4 = `datos_in[3]`.
- `valido` input 1: `datos_in` is valid.
- `listo` output 1: block can accept a word.
- `inyectar` input 8: XOR error mask. Used only under `HAMMING_INYECCION_EN`.
- `tx` output 1: serial line, idle high.
- `palabra_cod` output 8: clean codeword of the last accepted word.
- `ocupado` output 1: a frame is in progress.
- `fin` output 1: one-cycle pulse at the end of a frame.

## Operation
- Encoding uses Hamming positions 1..7, mapped to bit index position−1:
  - bit0 = p1 = d1^d2^d4
  - bit1 = p2 = d1^d3^d4
  - bit2 = d1
  - bit3 = p4 = d2^d3^d4
  - bit4 = d2
  - bit5 = d3
  - bit6 = d4
  - bit7 = even overall parity = XOR of bits 6:0
- Handshake: a transfer occurs on a rising edge with `valido && listo`.
  - `datos_in` (and `inyectar`) are sampled only on that edge.
  - `valido` while busy is ignored. There is no buffering.
- Frame layout, each bit held `CICLOS_POR_BIT` cycles:
  - start bit = 0
  - codeword bits 0..7, LSB first
  - stop bit = 1
- FSM states are REPOSO, INICIO, DATOS, PARADA.
  - REPOSO → INICIO on transfer.
  - INICIO → DATOS when the bit counter reaches `CICLOS_POR_BIT`−1.
  - DATOS stays for 8 bits. The bit index runs 0..7 and advances when the bit counter wraps. It exits to PARADA after index 7 completes.
  - PARADA → REPOSO when the bit counter wraps.
- Outputs by state:
  - `listo` = (state == REPOSO).
  - `ocupado` = !`listo`.
  - `tx` is registered: 1 in REPOSO and PARADA, 0 in INICIO, the shift-register bit in DATOS.
- `palabra_cod` updates on the transfer edge and holds until the next transfer.
- `fin` is asserted for exactly the last cycle of PARADA.
- Reset, including mid-frame, applies on the next edge:
  - state = REPOSO
  - `tx` = 1, `listo` = 1, `ocupado` = 0, `fin` = 0
  - `palabra_cod` = 8'h00
  - bit counter and bit index cleared; shift register cleared
  - No partial frame resumes.

## Timing
- Transfer at edge T: `tx` falls at T+1, and the start bit occupies cycles T+1 .. T+N, where N = `CICLOS_POR_BIT`.
- Codeword bit k occupies cycles T+1+N(k+1) .. T+N(k+2).
- Stop bit occupies cycles T+1+9N .. T+10N. `fin` is high in cycle T+10N.
- `listo` = 1 from cycle T+10N+1.
- With `valido` held high, back-to-back frames carry exactly one idle-high cycle between the stop bit and the next start bit. The frame period is 10N+1 cycles.
- N = 1 is legal: every state lasts one cycle per bit, and the counter wraps every cycle.
- Encoding latency: the codeword is registered one cycle after transfer. No combinational path exists from `datos_in` to `tx`.

## Configuration
- `HAMMING_INYECCION_EN` defined:
  - the transmitted word is codeword XOR `inyectar`, with `inyectar` captured on the transfer edge;
  - `palabra_cod` still shows the clean codeword.
  - A 1-bit mask exercises correction in the receiver; a 2-bit mask exercises double-error detection.
- `HAMMING_INYECCION_EN` undefined: `inyectar` is ignored, and the transmitted word equals `palabra_cod`.

## Test plan
- Reset, then `datos_in`=4'b1011 with `valido` pulsed, N=4:
  - `palabra_cod`=8'h55;
  - `tx` sequence is 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 4 cycles;
  - `fin` pulses at T+40; `listo` = 1 at T+41.
- `datos_in`=4'b0001 → `palabra_cod`=8'h87. `datos_in`=4'hF → 8'hFF. `datos_in`=4'h0 → 8'h00 (whole frame is 0s then stop 1).
- `valido` held high with alternating data, N=1: frames repeat every 11 cycles with one idle `tx`=1 cycle between them. Changes on `datos_in` mid-frame do not affect the frame in flight.
- Assert `rst` at bit 3 of DATOS: next cycle `tx`=1, `listo`=1, `palabra_cod`=8'h00, `fin` never pulses. A new transfer afterwards produces a clean full frame.
- With `HAMMING_INYECCION_EN` defined, `inyectar`=8'h04, data 4'b1011:
  - `tx` carries 8'h51 and `palabra_cod`=8'h55.
  - With `inyectar`=8'h06, `tx` carries 8'h53.
  - Undefined build: `tx` carries 8'h55 for any mask.
